hc595_chain_ctrl: RTL
=====================

// Module: hc595_chain_ctrl
// PURPOSE
//   Serialises a parallel frame into a chain of cascaded 74HC595 shift registers
//   (segment/digit drivers for the fare display) via ds/shcp/stcp/oe.
//   Generalises the fixed 14-bit, free-running 595 driver:
//   - configurable chain width, shift clock rate and bit order;
//   - valid/ready frame load with a shadow register;
//   - optional continuous refresh of the last frame;
//   - display blanking until the first frame is latched.
// PARAMETERS
//   DATA_W    16  total bits shifted per frame (8 per cascaded 595); range 2..64
//   CLK_DIV   4   sys_clk cycles per shcp period; even, >=2
//   MSB_FIRST 1   1: din[DATA_W-1] shifted first; 0: din[0] shifted first
//   REFRESH   1   1: re-send stored frame when idle; 0: shift only on new frames
// PORTS
//   sys_clk     in   1       system clock
//   sys_rst_n   in   1       async active-low reset
//   din         in   DATA_W  frame to shift (bit mapping set by MSB_FIRST)
//   din_valid   in   1       frame offered
//   din_ready   out  1       frame accepted when din_valid & din_ready at a rising edge
//   ds          out  1       595 serial data
//   shcp        out  1       595 shift clock
//   stcp        out  1       595 storage (latch) clock
//   oe          out  1       595 output enable, active low
//   busy        out  1       state != IDLE
//   frame_done  out  1       1-cycle pulse when a frame has been latched
// BEHAVIOUR
//   Reset (async, any state): all registered outputs and internal state cleared.
//   - Outputs: ds=0, shcp=0, stcp=0, busy=0, frame_done=0, oe=1.
//   - Internal: shadow=0, have_frame=0, state=IDLE.
//   - din_ready=0 while sys_rst_n=0.
//   - A frame in flight is discarded; no stcp pulse is issued.
//   Outputs are registered. Exception: din_ready = (state==IDLE) & sys_rst_n.
//   FSM IDLE -> SHIFT -> LATCH -> IDLE.
//   IDLE transitions:
//   - If din_valid: capture din into shadow, set have_frame=1, go to SHIFT.
//   - Else if REFRESH & have_frame: go to SHIFT, resending shadow.
//   - Else: stay in IDLE.
//   - A new frame always takes priority over a refresh.
//   SHIFT (div_cnt 0..CLK_DIV-1, bit_idx 0..DATA_W-1):
//   - ds takes the current bit at the entering edge and at each div_cnt wrap.
//   - Each bit is held for a full CLK_DIV period.
//   - shcp=1 for div_cnt in [CLK_DIV/2, CLK_DIV-1], else 0.
//   - The shcp rising edge is CLK_DIV/2 cycles after ds changes (setup = hold = CLK_DIV/2).
//   - After bit DATA_W-1 completes its period (DATA_W*CLK_DIV cycles), go to LATCH.
//   - shcp=0 and ds holds its last bit on LATCH entry.
//   LATCH:
//   - stcp=1 for CLK_DIV/2 cycles, then stcp=0 and frame_done=1 for one cycle.
//   - Then return to IDLE.
//   - oe is cleared to 0 with the first frame_done after reset and stays 0 until reset.
//   Timing (accept edge = cycle 0):
//   - stcp rises at cycle DATA_W*CLK_DIV.
//   - frame_done is high at cycle DATA_W*CLK_DIV + CLK_DIV/2.
//   - din_ready returns high in the following cycle.
//   - Back-to-back frames: period = DATA_W*CLK_DIV + CLK_DIV/2 + 1 cycles.
//   - din changes while busy are ignored; the shadow is stable for the whole frame.
//   - ds idles at its last value; shcp and stcp are never high in the same cycle.
// TESTING
//   1. Reset values, and REFRESH=0 with no din_valid for 200 cycles:
//      outputs stay at reset values, din_ready=1, no shcp edges.
//   2. DATA_W=16, CLK_DIV=4, MSB_FIRST=1, din=16'hA5C3, valid at cycle 0:
//      - 16 shcp rises at cycles 2,6,..,62, sampling 1010_0101_1100_0011;
//      - stcp high at cycles 64-65; frame_done at 66; oe 1->0 at 66.
//   3. MSB_FIRST=0, same frame:
//      ds sequence reversed (1100_0011_1010_0101 as sampled); timing unchanged.
//   4. REFRESH=1, one frame sent, din_valid held low:
//      - frame repeats every 67 cycles with identical ds pattern;
//      - assert din_valid with 16'h0001 mid-refresh: accepted only after the current
//        frame_done, then the new pattern repeats.
//   5. Reset asserted at cycle 30 of a frame:
//      - outputs return to reset values asynchronously; no stcp pulse;
//      - after release with REFRESH=1 and no new frame, nothing is shifted (have_frame=0).
//   6. DATA_W=14, CLK_DIV=4:
//      - din = {seg[0..7], sel[5:0]} = 14'h2A3F reproduces the legacy 14-bit display frame;
//      - stcp rises at cycle 56.

Source files
------------

// File: rtl/hc595_chain_ctrl.sv
// hc595_chain_ctrl: serialises a parallel frame into a cascaded 74HC595 chain.
// Valid/ready load into a shadow register, optional refresh, blank until first latch.
module hc595_chain_ctrl #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1,
  parameter int REFRESH   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ds,
  output logic              shcp,
  output logic              stcp,
  output logic              oe,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shadow;
  logic              have_frame;
  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  bit_idx;

  // Bit k of the shifted sequence, honouring the configured bit order.
  function automatic logic pick(
    input logic [DATA_W-1:0] f,
    input logic [IDX_W-1:0]  k
  );
    logic [IDX_W-1:0] j;
    j = (MSB_FIRST != 0) ? IDX_LAST - k : k;
    return f[j];
  endfunction

  assign din_ready = (state == IDLE) & sys_rst_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      have_frame <= 1'b0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      ds         <= 1'b0;
      shcp       <= 1'b0;
      stcp       <= 1'b0;
      oe         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (din_valid || (REFRESH != 0 && have_frame)) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            shcp    <= 1'b0;
            if (din_valid) begin
              shadow     <= din;
              have_frame <= 1'b1;
              ds         <= pick(din, '0);
            end else begin
              ds <= pick(shadow, '0);
            end
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            shcp    <= 1'b0;
            if (bit_idx == IDX_LAST) begin
              state <= LATCH;
              stcp  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              ds      <= pick(shadow, bit_idx + 1'b1);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            // shcp goes high for the second half of each bit period
            shcp    <= (div_cnt >= HALF_LAST);
          end
        end
        LATCH: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt    <= '0;
            stcp       <= 1'b0;
            frame_done <= 1'b1;
            oe         <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
